// File: rtl/mii_phy_pkg.sv
// Shared constants and FSM state encodings for the MII PHY endpoint.
package mii_phy_pkg;

  localparam logic [3:0] PRE_NIBBLE = 4'h5;
  localparam logic [3:0] SFD_NIBBLE = 4'hD;

  typedef logic [2:0] drv_state_t;
  localparam drv_state_t DRV_IDLE = 3'd0;
  localparam drv_state_t DRV_PRE  = 3'd1;
  localparam drv_state_t DRV_SFD  = 3'd2;
  localparam drv_state_t DRV_LO   = 3'd3;
  localparam drv_state_t DRV_HI   = 3'd4;
  localparam drv_state_t DRV_GAP  = 3'd5;

  typedef logic [1:0] cap_state_t;
  localparam cap_state_t CAP_IDLE = 2'd0;
  localparam cap_state_t CAP_PRE  = 2'd1;
  localparam cap_state_t CAP_LO   = 2'd2;
  localparam cap_state_t CAP_HI   = 2'd3;

endpackage

// File: rtl/mii_phy_endpoint_if.sv
// Bundle of the byte-stream and MII signals around the PHY endpoint.
// slave = the endpoint itself, master = the MAC / byte source / sink side.
interface mii_phy_endpoint_if;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [3:0]  mii_rxd;
  logic        mii_rx_dv;
  logic        mii_rx_er;
  logic [3:0]  mii_txd;
  logic        mii_tx_en;
  logic        mii_tx_er;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [15:0] tx_frame_count;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output mii_rxd, mii_rx_dv, mii_rx_er,
    input  mii_txd, mii_tx_en, mii_tx_er,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output tx_frame_count
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  mii_rxd, mii_rx_dv, mii_rx_er,
    output mii_txd, mii_tx_en, mii_tx_er,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  tx_frame_count
  );
endinterface

// File: rtl/mii_nibble_deframer.sv
// Capture path: strips preamble/SFD from MAC nibbles and rebuilds bytes, holding one
// byte back so the final byte can carry tlast/tuser one cycle after tx_en falls.
module mii_nibble_deframer
  import mii_phy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  txd,
  input  logic        tx_en,
  input  logic        tx_er,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic [15:0] frame_count
);

  cap_state_t state;
  logic [3:0] low_q;
  logic [7:0] buf_q;
  logic       buf_vld;
  logic       err_q;
  logic       bad_q;
  logic       frame_bad;

  // HI means a low nibble is latched and waiting; PRE means SFD never arrived.
  assign frame_bad = err_q | bad_q | tx_er_dummy(state);

  function automatic logic tx_er_dummy(input cap_state_t s);
    return (s == CAP_HI) || (s == CAP_PRE);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CAP_IDLE;
      low_q       <= 4'h0;
      buf_q       <= 8'h00;
      buf_vld     <= 1'b0;
      err_q       <= 1'b0;
      bad_q       <= 1'b0;
      m_tdata     <= 8'h00;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tuser     <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
      if (tx_en) begin
        err_q <= err_q | tx_er;
        case (state)
          CAP_IDLE, CAP_PRE: begin
            if (txd == SFD_NIBBLE) begin
              state <= CAP_LO;
            end else begin
              state <= CAP_PRE;
              if (txd != PRE_NIBBLE) bad_q <= 1'b1;
            end
          end
          CAP_LO: begin
            low_q <= txd;
            state <= CAP_HI;
          end
          CAP_HI: begin
            if (buf_vld) begin
              m_tdata  <= buf_q;
              m_tvalid <= 1'b1;
            end
            buf_q   <= {txd, low_q};
            buf_vld <= 1'b1;
            state   <= CAP_LO;
          end
          default: state <= CAP_IDLE;
        endcase
      end else if (state != CAP_IDLE) begin
        state   <= CAP_IDLE;
        buf_vld <= 1'b0;
        err_q   <= 1'b0;
        bad_q   <= 1'b0;
        if (buf_vld) begin
          m_tdata  <= buf_q;
          m_tvalid <= 1'b1;
          m_tlast  <= 1'b1;
          m_tuser  <= frame_bad;
        end
        if (state != CAP_PRE) frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/mii_phy_endpoint.sv
// PHY-side MII endpoint: frames AXI-stream bytes into preamble/SFD/nibbles toward the
// MAC with an enforced inter-frame gap, and hands MAC nibbles to the capture deframer.
module mii_phy_endpoint
  import mii_phy_pkg::*;
#(
  parameter int IFG_NIBBLES      = 24,
  parameter int PREAMBLE_NIBBLES = 15
) (
  input logic               clk,
  input logic               rst,
  mii_phy_endpoint_if.slave bus
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_NIBBLES - 1);
  localparam logic [7:0] IFG_LOAD = 8'(IFG_NIBBLES);

  drv_state_t state;
  drv_state_t state_nxt;
  logic [7:0] pre_cnt;
  logic [7:0] ifg_cnt;
  logic [7:0] byte_q;
  logic       last_q;
  logic       user_q;
  logic       drain;
  logic       take;
  logic       ifg_ok;
  logic [3:0] rxd;
  logic       dv;
  logic       er;
  logic       tready;

  // The gap completes at the end of the cycle where the count reaches 1, so the
  // preamble can begin exactly IFG_NIBBLES idle cycles after dv falls.
  assign ifg_ok = (ifg_cnt <= 8'd1);

  always_comb begin
    state_nxt = state;
    rxd       = 4'h0;
    dv        = 1'b0;
    er        = 1'b0;
    tready    = 1'b0;
    take      = 1'b0;
    case (state)
      DRV_IDLE: begin
        tready = drain;
        if (!drain && bus.s_axis_tvalid && ifg_ok) state_nxt = DRV_PRE;
      end
      DRV_PRE: begin
        dv  = 1'b1;
        rxd = PRE_NIBBLE;
        if (pre_cnt == PRE_LAST) state_nxt = DRV_SFD;
      end
      DRV_SFD: begin
        dv        = 1'b1;
        rxd       = SFD_NIBBLE;
        tready    = 1'b1;
        take      = 1'b1;
        state_nxt = DRV_LO;
      end
      DRV_LO: begin
        dv        = 1'b1;
        rxd       = byte_q[3:0];
        er        = last_q & user_q;
        state_nxt = DRV_HI;
      end
      DRV_HI: begin
        dv  = 1'b1;
        rxd = byte_q[7:4];
        if (last_q) begin
          er        = user_q;
          state_nxt = DRV_GAP;
        end else begin
          tready = 1'b1;
          if (bus.s_axis_tvalid) begin
            take      = 1'b1;
            state_nxt = DRV_LO;
          end else begin
            er        = 1'b1;
            state_nxt = DRV_GAP;
          end
        end
      end
      DRV_GAP: begin
        tready    = drain;
        state_nxt = DRV_IDLE;
      end
      default: state_nxt = DRV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DRV_IDLE;
      pre_cnt <= 8'd0;
      ifg_cnt <= IFG_LOAD;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
      drain   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pre_cnt <= (state == DRV_PRE) ? pre_cnt + 8'd1 : 8'd0;
      if (state == DRV_HI && state_nxt == DRV_GAP) ifg_cnt <= IFG_LOAD;
      else if (ifg_cnt != 8'd0)                      ifg_cnt <= ifg_cnt - 8'd1;
      if (take) begin
        byte_q <= bus.s_axis_tdata;
        last_q <= bus.s_axis_tlast;
        user_q <= bus.s_axis_tuser;
      end
      // An underflowed frame's remaining bytes are swallowed up to its tlast.
      if (state == DRV_HI && !last_q && !bus.s_axis_tvalid) drain <= 1'b1;
      else if (drain && bus.s_axis_tvalid && bus.s_axis_tlast) drain <= 1'b0;
    end
  end

  assign bus.mii_rxd       = rxd;
  assign bus.mii_rx_dv     = dv;
  assign bus.mii_rx_er     = er;
  assign bus.s_axis_tready = tready;

  mii_nibble_deframer u_deframer (
    .clk        (clk),
    .rst        (rst),
    .txd        (bus.mii_txd),
    .tx_en      (bus.mii_tx_en),
    .tx_er      (bus.mii_tx_er),
    .m_tdata    (bus.m_axis_tdata),
    .m_tvalid   (bus.m_axis_tvalid),
    .m_tlast    (bus.m_axis_tlast),
    .m_tuser    (bus.m_axis_tuser),
    .frame_count(bus.tx_frame_count)
  );

endmodule

// File: tb/tb_mii_phy_endpoint.sv
// Directed bench for mii_phy_endpoint: drive-path framing, IFG, underflow, reset,
// and capture-path byte reassembly with error flagging.
module tb_mii_phy_endpoint;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mii_phy_endpoint_if bus();

  mii_phy_endpoint #(.IFG_NIBBLES(24), .PREAMBLE_NIBBLES(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] src_dat [16];
  logic       src_last[16];
  int         src_n, src_idx, hold_at, hold_cnt, rst_k, rst_cyc;
  logic [6:0] lg[128];   // {tready, dv, er, rxd} per cycle

  logic [3:0] nib[64];
  int         nn, er_at, ncap;
  logic [9:0] cap[8];    // {tuser, tlast, tdata}
  logic [15:0] cnt_at_last;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [6:0] lgv(input int i);
    return (i >= 0 && i < 128) ? lg[i] : 7'h7F;
  endfunction

  function automatic int find_dv(input int from, input logic want);
    for (int i = from; i < 128; i++) if (i >= 0 && lg[i][5] == want) return i;
    return -1;
  endfunction

  // One cycle per iteration: present source byte, sample outputs, advance on handshake.
  task automatic drive_run(input int ncyc);
    logic hs;
    int   dv_cnt;
    dv_cnt  = 0;
    rst_cyc = -1;
    for (int i = 0; i < 128; i++) lg[i] = 7'h00;
    for (int c = 0; c < ncyc; c++) begin
      rst = 1'b0;
      if (src_idx < src_n && !(src_idx == hold_at && hold_cnt > 0)) begin
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = src_dat[src_idx];
        bus.s_axis_tlast  = src_last[src_idx];
      end else begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 8'h00;
        bus.s_axis_tlast  = 1'b0;
      end
      if (src_idx == hold_at && hold_cnt > 0) hold_cnt--;
      #1;
      lg[c] = {bus.s_axis_tready, bus.mii_rx_dv, bus.mii_rx_er, bus.mii_rxd};
      if (bus.mii_rx_dv) dv_cnt++;
      if (rst_k > 0 && dv_cnt == rst_k && rst_cyc < 0) begin
        rst     = 1'b1;
        rst_cyc = c;
      end
      hs = bus.s_axis_tvalid && bus.s_axis_tready && !rst;
      @(posedge clk); #1;
      if (hs) src_idx++;
    end
    rst = 1'b0;
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic load_src4(input logic [31:0] bytes_le);
    for (int i = 0; i < 4; i++) begin
      src_dat[i]  = bytes_le[8*i +: 8];
      src_last[i] = (i == 3);
    end
    src_n = 4; src_idx = 0; hold_at = -1; hold_cnt = 0; rst_k = 0;
  endtask

  task automatic load_pre();
    for (int i = 0; i < 15; i++) nib[i] = 4'h5;
    nib[15] = 4'hD;
    nn = 16; er_at = -1;
  endtask

  task automatic mac_run();
    ncap = 0;
    for (int c = 0; c < nn + 4; c++) begin
      bus.mii_tx_en = (c < nn);
      bus.mii_txd   = (c < nn) ? nib[c] : 4'h0;
      bus.mii_tx_er = (c == er_at);
      @(posedge clk); #1;
      if (bus.m_axis_tvalid && ncap < 8) begin
        cap[ncap] = {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata};
        ncap++;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tlast) cnt_at_last = bus.tx_frame_count;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int r, f, r2;
    logic [3:0] exp_nib;
    logic [7:0] b;
    bus.s_axis_tdata = 8'h00; bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;  bus.s_axis_tuser  = 1'b0;
    bus.mii_txd = 4'h0; bus.mii_tx_en = 1'b0; bus.mii_tx_er = 1'b0;
    cnt_at_last = 16'h0;
    rst = 1'b1;
    idle(4);
    rst = 1'b0;

    // Reset state
    chk("rst_rxd",   0, 32'(bus.mii_rxd), 0);
    chk("rst_dv",    0, 32'(bus.mii_rx_dv), 0);
    chk("rst_er",    0, 32'(bus.mii_rx_er), 0);
    chk("rst_tready",0, 32'(bus.s_axis_tready), 0);
    chk("rst_mvld",  0, 32'(bus.m_axis_tvalid), 0);
    chk("rst_mlast", 0, 32'(bus.m_axis_tlast), 0);
    chk("rst_muser", 0, 32'(bus.m_axis_tuser), 0);
    chk("rst_count", 0, 32'(bus.tx_frame_count), 0);
    idle(30);

    // Single 4-byte frame: 15x5, D, 1,0,3,2,5,4,7,6, then dv low
    load_src4(32'h67452301);
    drive_run(60);
    r = find_dv(0, 1'b1);
    chk("t1_rise", 0, 32'(r >= 0), 1);
    if (r < 0) r = 0;
    for (int k = 0; k < 24; k++) begin
      if (k < 15)       exp_nib = 4'h5;
      else if (k == 15) exp_nib = 4'hD;
      else begin
        b = src_dat[(k - 16) / 2];
        exp_nib = ((k % 2) == 0) ? b[3:0] : b[7:4];
      end
      chk("t1_nib", k, 32'(lgv(r + k) & 7'h3F), 32'({2'b10, exp_nib}));
    end
    chk("t1_end", 24, 32'(lgv(r + 24) & 7'h3F), 0);
    for (int k = 15; k < 24; k++)
      chk("t1_tready", k, 32'(lgv(r + k) >> 6), 32'((k % 2 == 1) && (k != 23)));
    chk("t1_consumed", 0, src_idx, 4);
    idle(30);

    // Back-to-back frames: second preamble exactly 24 cycles after dv falls
    load_src4(32'h67452301);
    src_dat[4] = 8'h89; src_dat[5] = 8'hAB; src_dat[6] = 8'hCD; src_dat[7] = 8'hEF;
    for (int i = 4; i < 8; i++) src_last[i] = (i == 7);
    src_n = 8;
    drive_run(110);
    r  = find_dv(0, 1'b1);
    f  = find_dv(r, 1'b0);
    r2 = find_dv(f, 1'b1);
    chk("t2_len", 0, f - r, 24);
    chk("t2_gap", 0, r2 - f, 24);
    chk("t2_f2_lo", 0, 32'(lgv(r2 + 16) & 7'h3F), 32'h29);
    chk("t2_f2_hi", 0, 32'(lgv(r2 + 17) & 7'h3F), 32'h28);
    chk("t2_consumed", 0, src_idx, 8);
    idle(30);

    // Underflow after 0x23: rx_er on the 0x2 nibble, then the rest drained with no dv
    load_src4(32'h67452301);
    hold_at = 2; hold_cnt = 3;
    drive_run(60);
    r = find_dv(0, 1'b1);
    if (r < 0) r = 0;
    chk("t3_lo1", 0, 32'(lgv(r + 16) & 7'h3F), 32'h21);
    chk("t3_hi0", 0, 32'(lgv(r + 17) & 7'h3F), 32'h20);
    chk("t3_lo3", 0, 32'(lgv(r + 18) & 7'h3F), 32'h23);
    chk("t3_hi2_er", 0, 32'(lgv(r + 19) & 7'h3F), 32'h32);
    chk("t3_dv_fall", 0, 32'(lgv(r + 20) & 7'h3F), 0);
    chk("t3_no_dv", 0, find_dv(r + 20, 1'b1), -1);
    chk("t3_drained", 0, src_idx, 4);
    idle(30);

    // Reset while in HI of the first byte
    load_src4(32'h67452301);
    rst_k = 18;
    drive_run(70);
    chk("t4_rst_hit", 0, 32'(rst_cyc >= 0), 1);
    if (rst_cyc < 0) rst_cyc = 0;
    chk("t4_in_hi", 0, 32'(lgv(rst_cyc) & 7'h3F), 32'h20);
    chk("t4_after", 0, 32'(lgv(rst_cyc + 1)), 0);
    r2 = find_dv(rst_cyc + 1, 1'b1);
    chk("t4_idle_cycles", 0, r2 - (rst_cyc + 1), 24);
    chk("t4_restart_lo", 0, 32'(lgv(r2 + 16) & 7'h3F), 32'h23);
    idle(40);

    // Capture: A,5,F,0 -> 0x5A, then 0x0F with tlast
    chk("c1_count0", 0, 32'(bus.tx_frame_count), 0);
    load_pre();
    nib[16] = 4'hA; nib[17] = 4'h5; nib[18] = 4'hF; nib[19] = 4'h0; nn = 20;
    mac_run();
    chk("c1_nbytes", 0, ncap, 2);
    chk("c1_b0", 0, 32'(cap[0]), 32'h05A);
    chk("c1_b1", 0, 32'(cap[1]), 32'h10F);
    chk("c1_count", 0, 32'(bus.tx_frame_count), 1);
    chk("c1_count_at_last", 0, 32'(cnt_at_last), 1);

    // tx_er on a data nibble
    load_pre();
    nib[16] = 4'h1; nib[17] = 4'h2; nib[18] = 4'h3; nib[19] = 4'h4; nn = 20; er_at = 17;
    mac_run();
    chk("c2_nbytes", 0, ncap, 2);
    chk("c2_b0", 0, 32'(cap[0]), 32'h021);
    chk("c2_b1", 0, 32'(cap[1]), 32'h343);
    chk("c2_count", 0, 32'(bus.tx_frame_count), 2);

    // Odd nibble count
    load_pre();
    nib[16] = 4'h1; nib[17] = 4'h2; nib[18] = 4'h3; nn = 19;
    mac_run();
    chk("c3_nbytes", 0, ncap, 1);
    chk("c3_b0", 0, 32'(cap[0]), 32'h321);
    chk("c3_count", 0, 32'(bus.tx_frame_count), 3);

    // Preamble only, no SFD: nothing emitted, not counted
    for (int i = 0; i < 6; i++) nib[i] = 4'h5;
    nn = 6; er_at = -1;
    mac_run();
    chk("c4_nbytes", 0, ncap, 0);
    chk("c4_count", 0, 32'(bus.tx_frame_count), 3);

    // SFD with no data: nothing emitted, but counted
    load_pre();
    mac_run();
    chk("c5_nbytes", 0, ncap, 0);
    chk("c5_count", 0, 32'(bus.tx_frame_count), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
